// File: rtl/oled_frame_transmitter_if.sv
// Frame interface between the drawing logic and the SSD1331 pixel-stream transmitter.
// The transmitter takes the master side; the drawing logic takes the slave side.
interface oled_frame_transmitter_if;
  logic        enable;
  logic [15:0] pixel_data;
  logic        frame_begin;
  logic        sending_pixels;
  logic        sample_pixel;
  logic [12:0] pixel_index;
  logic        cs;
  logic        sdin;
  logic        sclk;
  logic        d_cn;

  modport master (
    input  enable,
    input  pixel_data,
    output frame_begin,
    output sending_pixels,
    output sample_pixel,
    output pixel_index,
    output cs,
    output sdin,
    output sclk,
    output d_cn
  );

  modport slave (
    output enable,
    output pixel_data,
    input  frame_begin,
    input  sending_pixels,
    input  sample_pixel,
    input  pixel_index,
    input  cs,
    input  sdin,
    input  sclk,
    input  d_cn
  );
endinterface

// File: rtl/oled_frame_transmitter.sv
// Streams a window-setup command prefix and then a full RGB565 frame to the
// 96x64 SSD1331 over 4-wire SPI, fetching each pixel one byte ahead of use.
module oled_frame_transmitter #(
  parameter int WIDTH     = 96,
  parameter int HEIGHT    = 64,
  parameter int FRAME_GAP = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  oled_frame_transmitter_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_PIX   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int              GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'(FRAME_GAP - 1);
  localparam logic [12:0]     LAST_PIX = 13'(WIDTH * HEIGHT - 1);

  logic [2:0]    r_state;
  logic [3:0]    r_cyc;
  logic [2:0]    r_byte;
  logic [7:0]    r_shift;
  logic [7:0]    r_pix_lo;
  logic          r_hi;
  logic          r_last;
  logic [GW-1:0] r_gap;
  logic          r_cs;
  logic          r_sclk;
  logic          r_sdin;
  logic          r_d_cn;
  logic          r_frame_begin;
  logic          r_sending;
  logic          r_sample;
  logic [12:0]   r_pixel_index;

  logic [7:0]    w_next_byte;
  logic          w_fetch_byte;
  logic          w_frame_end;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h15;
      3'd1:    return 8'h00;
      3'd2:    return 8'(WIDTH - 1);
      3'd3:    return 8'h75;
      3'd4:    return 8'h00;
      default: return 8'(HEIGHT - 1);
    endcase
  endfunction

  // A "fetch" byte is the one during which the next pixel is indexed and sampled.
  always_comb begin
    w_fetch_byte = ((r_state == S_CMD) && (r_byte == 3'd5)) ||
                   ((r_state == S_PIX) && !r_hi && !r_last);
    w_frame_end  = (r_state == S_PIX) && !r_hi && r_last;
    w_next_byte  = 8'h00;
    case (r_state)
      S_START: w_next_byte = cmd_byte(3'd0);
      S_CMD:   w_next_byte = (r_byte == 3'd5) ? bus.pixel_data[15:8] : cmd_byte(r_byte + 3'd1);
      S_PIX:   w_next_byte = r_hi ? r_pix_lo : bus.pixel_data[15:8];
      default: w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cyc         <= 4'd0;
      r_byte        <= 3'd0;
      r_shift       <= 8'h00;
      r_pix_lo      <= 8'h00;
      r_hi          <= 1'b0;
      r_last        <= 1'b0;
      r_gap         <= '0;
      r_cs          <= 1'b1;
      r_sclk        <= 1'b1;
      r_sdin        <= 1'b0;
      r_d_cn        <= 1'b0;
      r_frame_begin <= 1'b0;
      r_sending     <= 1'b0;
      r_sample      <= 1'b0;
      r_pixel_index <= 13'd0;
    end else begin
      r_frame_begin <= 1'b0;
      r_sample      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_state       <= S_START;
            r_frame_begin <= 1'b1;
            r_pixel_index <= 13'd0;
          end
        end
        S_START: begin
          r_state <= S_CMD;
          r_byte  <= 3'd0;
          r_last  <= 1'b0;
          r_cyc   <= 4'd0;
          r_cs    <= 1'b0;
          r_d_cn  <= 1'b0;
          r_sclk  <= 1'b0;
          r_shift <= w_next_byte;
          r_sdin  <= w_next_byte[7];
        end
        S_CMD, S_PIX: begin
          if (!r_cyc[0]) begin
            r_sclk <= 1'b1;
            r_cyc  <= r_cyc + 4'd1;
            if ((r_cyc == 4'd14) && w_fetch_byte) begin
              r_sample <= 1'b1;
            end
          end else if (r_cyc != 4'd15) begin
            r_sclk  <= 1'b0;
            r_sdin  <= r_shift[6];
            r_shift <= {r_shift[6:0], 1'b0};
            r_cyc   <= r_cyc + 4'd1;
          end else if (w_frame_end) begin
            r_state   <= S_GAP;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b1;
            r_sdin    <= 1'b0;
            r_d_cn    <= 1'b0;
            r_sending <= 1'b0;
            r_last    <= 1'b0;
            r_gap     <= '0;
          end else begin
            r_cyc   <= 4'd0;
            r_sclk  <= 1'b0;
            r_shift <= w_next_byte;
            r_sdin  <= w_next_byte[7];
            if (w_fetch_byte) begin
              r_pix_lo <= bus.pixel_data[7:0];
            end
            if (r_state == S_CMD) begin
              if (r_byte == 3'd5) begin
                r_state   <= S_PIX;
                r_d_cn    <= 1'b1;
                r_sending <= 1'b1;
                r_hi      <= 1'b1;
              end else begin
                r_byte <= r_byte + 3'd1;
              end
            end else begin
              r_hi <= !r_hi;
              // Entering a low byte: index the next pixel, or flag the final one.
              if (r_hi) begin
                if (r_pixel_index == LAST_PIX) begin
                  r_last <= 1'b1;
                end else begin
                  r_pixel_index <= r_pixel_index + 13'd1;
                end
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            if (bus.enable) begin
              r_state       <= S_START;
              r_frame_begin <= 1'b1;
              r_pixel_index <= 13'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cs             = r_cs;
  assign bus.sclk           = r_sclk;
  assign bus.sdin           = r_sdin;
  assign bus.d_cn           = r_d_cn;
  assign bus.frame_begin    = r_frame_begin;
  assign bus.sending_pixels = r_sending;
  assign bus.sample_pixel   = r_sample;
  assign bus.pixel_index    = r_pixel_index;
endmodule

// File: tb/tb_oled_frame_transmitter.sv
// Bench for oled_frame_transmitter: a full-size instance for the command prefix and
// reset behaviour, and a reduced 8x4 instance for whole frames, gaps and enable handling.
`timescale 1ns/1ps
module tb_oled_frame_transmitter;
  localparam int S_W   = 8;
  localparam int S_H   = 4;
  localparam int S_G   = 20;
  localparam int S_PIX = S_W * S_H;
  localparam logic [19:0] RST_OUTS = {2'b11, 18'd0};

  logic clk     = 1'b0;
  logic f_rst_n = 1'b0;
  logic s_rst_n = 1'b0;
  logic f_mode  = 1'b1;
  logic s_mode  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] pix_model(input logic mode, input logic [12:0] idx);
    if (mode && idx == 13'd0) return 16'hF800;
    if (mode && idx == 13'd1) return 16'h07E0;
    return {3'b000, idx};
  endfunction

  oled_frame_transmitter_if f_bus ();
  oled_frame_transmitter_if s_bus ();

  assign f_bus.pixel_data = pix_model(f_mode, f_bus.pixel_index);
  assign s_bus.pixel_data = pix_model(s_mode, s_bus.pixel_index);

  oled_frame_transmitter u_full (
    .clk   (clk),
    .reset (f_rst_n),
    .bus   (f_bus)
  );

  oled_frame_transmitter #(.WIDTH(S_W), .HEIGHT(S_H), .FRAME_GAP(S_G)) u_small (
    .clk   (clk),
    .reset (s_rst_n),
    .bus   (s_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] f_outs();
    return {f_bus.cs, f_bus.sclk, f_bus.sdin, f_bus.d_cn, f_bus.frame_begin,
            f_bus.sending_pixels, f_bus.sample_pixel, f_bus.pixel_index};
  endfunction

  function automatic logic [19:0] s_outs();
    return {s_bus.cs, s_bus.sclk, s_bus.sdin, s_bus.d_cn, s_bus.frame_begin,
            s_bus.sending_pixels, s_bus.sample_pixel, s_bus.pixel_index};
  endfunction

  // Full-size instance: expected bytes and command-phase cycle count
  logic [8:0] f_exp_q[$];
  int         f_cmd_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (f_bus.frame_begin) f_cmd_cyc = 0;
    else if (!f_bus.cs && !f_bus.d_cn) f_cmd_cyc++;
  end

  task automatic full_read_byte(output logic [8:0] v);
    logic prev;
    int   bits;
    int   guard;
    prev  = f_bus.sclk;
    bits  = 0;
    guard = 0;
    v     = 9'd0;
    while (bits < 8 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (!f_bus.cs && f_bus.sclk && !prev) begin
        v = {f_bus.d_cn, v[6:0], f_bus.sdin};
        bits++;
      end
      prev = f_bus.sclk;
    end
    check("f_byte_timeout", bits, 8);
  endtask

  task automatic full_push_cmd();
    f_exp_q.push_back({1'b0, 8'h15});
    f_exp_q.push_back({1'b0, 8'h00});
    f_exp_q.push_back({1'b0, 8'h5F});
    f_exp_q.push_back({1'b0, 8'h75});
    f_exp_q.push_back({1'b0, 8'h00});
    f_exp_q.push_back({1'b0, 8'h3F});
  endtask

  task automatic full_read_expected(input int n);
    logic [8:0] v;
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      full_read_byte(v);
      e = f_exp_q.pop_front();
      $display("full byte d_cn=%0b data=%02h", v[8], v[7:0]);
      check("f_byte", v, e);
    end
  endtask

  // Reduced instance: scoreboard fed at frame_begin / sample_pixel, drained by SPI decode
  logic [8:0]  s_exp_q[$];
  logic [12:0] s_exp_idx   = 13'd0;
  logic [7:0]  s_shift     = 8'h00;
  logic [15:0] s_pix       = 16'h0000;
  logic        s_prev_sclk = 1'b1;
  int          s_nbit      = 0;
  int          s_frames    = 0;
  int          s_samples   = 0;
  int          s_send_cyc  = 0;
  int          s_cmd_cyc   = 0;

  initial forever begin
    @(negedge clk);
    if (!s_rst_n) begin
      s_prev_sclk = 1'b1;
      s_nbit      = 0;
      s_exp_q.delete();
    end else begin
      if (s_bus.frame_begin) begin
        s_frames++;
        s_samples  = 0;
        s_send_cyc = 0;
        s_cmd_cyc  = 0;
        s_exp_idx  = 13'd0;
        s_exp_q.push_back({1'b0, 8'h15});
        s_exp_q.push_back({1'b0, 8'h00});
        s_exp_q.push_back({1'b0, 8'(S_W - 1)});
        s_exp_q.push_back({1'b0, 8'h75});
        s_exp_q.push_back({1'b0, 8'h00});
        s_exp_q.push_back({1'b0, 8'(S_H - 1)});
      end
      if (s_bus.sample_pixel) begin
        check("s_sample_index", s_bus.pixel_index, s_exp_idx);
        s_pix = pix_model(s_mode, s_exp_idx);
        s_exp_q.push_back({1'b1, s_pix[15:8]});
        s_exp_q.push_back({1'b1, s_pix[7:0]});
        s_exp_idx = s_exp_idx + 13'd1;
        s_samples++;
      end
      if (s_bus.sending_pixels) s_send_cyc++;
      if (!s_bus.cs && !s_bus.d_cn) s_cmd_cyc++;
      if (!s_bus.cs && s_bus.sclk && !s_prev_sclk) begin
        s_shift = {s_shift[6:0], s_bus.sdin};
        s_nbit++;
        if (s_nbit == 8) begin
          s_nbit = 0;
          $display("small frame %0d byte d_cn=%0b data=%02h", s_frames, s_bus.d_cn, s_shift);
          if (s_exp_q.size() == 0) check("s_unexpected_byte", 0, 1);
          else check("s_byte", {s_bus.d_cn, s_shift}, s_exp_q.pop_front());
        end
      end
      s_prev_sclk = s_bus.sclk;
    end
  end

  task automatic s_wait_fb(input string tag, output time t);
    int g;
    g = 0;
    while (!s_bus.frame_begin && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check(tag, 32'(g < 5000), 1);
    t = $time;
  endtask

  task automatic s_wait_frame_end(input string tag);
    int g;
    g = 0;
    while (!s_bus.sending_pixels && g < 5000) begin
      @(negedge clk);
      g++;
    end
    while (s_bus.sending_pixels && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check(tag, 32'(g < 5000), 1);
  endtask

  task automatic s_check_frame(input string tag);
    check({tag, "_samples"}, s_samples, S_PIX);
    check({tag, "_send_cycles"}, s_send_cyc, S_PIX * 32);
    check({tag, "_cmd_cycles"}, s_cmd_cyc, 96);
    check({tag, "_queue_drained"}, s_exp_q.size(), 0);
  endtask

  initial begin
    time t0;
    time t1;
    int  g;
    int  gap;
    int  cs_low;
    int  fbs;

    f_bus.enable = 1'b1;
    s_bus.enable = 1'b1;
    repeat (4) @(negedge clk);
    check("f_reset_outs", f_outs(), RST_OUTS);
    check("s_reset_outs", s_outs(), RST_OUTS);

    // Release: nothing until the next rising edge, then frame_begin
    f_rst_n = 1'b1;
    #1 check("f_fb_before_edge", f_bus.frame_begin, 0);
    @(posedge clk);
    #1 check("f_fb_after_edge", f_bus.frame_begin, 1);
    check("f_index_at_start", f_bus.pixel_index, 0);
    full_push_cmd();
    f_exp_q.push_back({1'b1, 8'hF8});
    f_exp_q.push_back({1'b1, 8'h00});
    f_exp_q.push_back({1'b1, 8'h07});
    f_exp_q.push_back({1'b1, 8'hE0});
    full_read_expected(10);
    check("f_cmd_cycles", f_cmd_cyc, 96);

    // Asynchronous reset in the middle of the pixel phase
    g = 0;
    while (f_bus.pixel_index != 13'd100 && g < 10000) begin
      @(negedge clk);
      g++;
    end
    check("f_reach_p100", 32'(g < 10000), 1);
    #2 f_rst_n = 1'b0;
    #1 check("f_async_reset_outs", f_outs(), RST_OUTS);
    f_exp_q.delete();
    repeat (3) @(negedge clk);
    f_rst_n = 1'b1;
    @(posedge clk);
    #1 check("f_restart_fb", f_bus.frame_begin, 1);
    check("f_restart_index", f_bus.pixel_index, 0);
    full_push_cmd();
    full_read_expected(6);
    @(negedge clk);
    check("f_restart_cmd_cycles", f_cmd_cyc, 96);
    check("f_restart_dcn_data", f_bus.d_cn, 1);
    f_rst_n = 1'b0;

    // Reduced instance: two back-to-back frames, then enable dropped mid-frame
    @(negedge clk);
    s_rst_n = 1'b1;
    s_wait_fb("s_fb1_seen", t0);
    s_wait_frame_end("s_frame1_end");
    s_check_frame("s_frame1");
    gap    = 0;
    cs_low = 0;
    while (!s_bus.frame_begin && gap < 200) begin
      if (!s_bus.cs) cs_low++;
      gap++;
      @(negedge clk);
    end
    check("s_gap_cycles", gap, S_G);
    check("s_gap_cs_high", cs_low, 0);
    s_wait_fb("s_fb2_seen", t1);
    check("s_frame_period", 32'((t1 - t0) / 10), 1 + 96 + S_PIX * 32 + S_G);

    g = 0;
    while (s_bus.pixel_index != 13'd15 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("s_reach_p15", 32'(g < 2000), 1);
    s_bus.enable = 1'b0;
    s_wait_frame_end("s_frame2_end");
    s_check_frame("s_frame2");
    check("s_frame2_last_index", s_bus.pixel_index, S_PIX - 1);
    cs_low = 0;
    fbs    = 0;
    repeat (S_G + 100) begin
      @(negedge clk);
      if (!s_bus.cs) cs_low++;
      if (s_bus.frame_begin) fbs++;
    end
    check("s_idle_cs_high", cs_low, 0);
    check("s_no_restart", fbs, 0);

    // From IDLE, frame_begin one cycle after enable; colour pixels on this frame
    s_mode = 1'b1;
    s_bus.enable = 1'b1;
    @(posedge clk);
    #1 check("s_fb_from_idle", s_bus.frame_begin, 1);
    s_wait_frame_end("s_frame3_end");
    s_check_frame("s_frame3");
    s_bus.enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
